// File: rtl/mem_access_responder.sv
// mem_access_responder: single-outstanding memory-port responder.
// Accepts one read/write request from the core, drives it onto an SRAM-style
// bus for a fixed number of wait states, then waits for the memory
// acknowledge before completing with a one-cycle response pulse.
// Optional feature macro: MEM_TIMEOUT_EN (aborts an access that is never
// acknowledged and flags it on o_rsp_err).
module mem_access_responder #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned WAIT_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_req_ready,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_busy,
  output logic                  o_mem_cs,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ack
);

  // Wait counter must hold WAIT_CYCLES; keep at least one bit when it is 0.
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            err_q, err_d;

  // Timeout counter and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end

  assign o_rsp_err = err_q;
`else
  assign o_rsp_err = 1'b0;
`endif

  // State and capture registers; an async reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and capture logic for the request/access/response sequence.
  always_comb begin
    // NOTE: every target defaults to its held value first so no latch is inferred.
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
`ifdef MEM_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          write_d = i_req_write;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = WAIT_LOAD;
`ifdef MEM_TIMEOUT_EN
        tcnt_d  = '0;
`endif
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q != '0) begin
          // Ack is not looked at until the wait states have elapsed.
          cnt_d = cnt_q - 1'b1;
        end else if (i_mem_ack) begin
          // Ack wins over a timeout landing on the same edge.
          if (!write_q) rdata_d = i_mem_rdata;
          state_d = ST_RESP;
        end
`ifdef MEM_TIMEOUT_EN
        else begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_d == TO_LIMIT) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_mem_cs    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign o_mem_we    = o_mem_cs & write_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_rsp_valid = (state_q == ST_RESP);
  assign o_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_responder.sv
// Directed self-checking bench for mem_access_responder (WAIT_CYCLES=2).
module tb_mem_access_responder;

  logic       clk;
  logic       rst_n;
  logic       i_req_valid;
  logic       i_req_write;
  logic [7:0] i_req_addr;
  logic [7:0] i_req_wdata;
  logic       o_req_ready;
  logic       o_rsp_valid;
  logic [7:0] o_rsp_rdata;
  logic       o_rsp_err;
  logic       o_busy;
  logic       o_mem_cs;
  logic       o_mem_we;
  logic [7:0] o_mem_addr;
  logic [7:0] o_mem_wdata;
  logic [7:0] i_mem_rdata;
  logic       i_mem_ack;

  int checks   = 0;
  int failures = 0;

  mem_access_responder #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (8),
    .WAIT_CYCLES   (2),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req_valid(i_req_valid),
    .i_req_write(i_req_write),
    .i_req_addr (i_req_addr),
    .i_req_wdata(i_req_wdata),
    .o_req_ready(o_req_ready),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err  (o_rsp_err),
    .o_busy     (o_busy),
    .o_mem_cs   (o_mem_cs),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata),
    .i_mem_ack  (i_mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request with ack held high and follow it to completion,
  // checking the bus every chip-select cycle and the response pulse.
  task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rdata, input string tag);
    int cs_cycles;
    int n;
    i_req_valid = 1'b1;
    i_req_write = w;
    i_req_addr  = a;
    i_req_wdata = d;
    check({tag, "_ready_before"}, o_req_ready, 1'b1);
    tick();
    i_req_valid = 1'b0;
    cs_cycles = 0;
    n = 0;
    while (!o_rsp_valid && n < 20) begin
      if (o_mem_cs) begin
        cs_cycles++;
        check({tag, "_we"}, o_mem_we, w);
        check({tag, "_addr"}, o_mem_addr, a);
        check({tag, "_wdata"}, o_mem_wdata, d);
      end
      tick();
      n++;
    end
    check({tag, "_rsp_seen"}, o_rsp_valid, 1'b1);
    check({tag, "_cs_cycles"}, cs_cycles, 4);
    check({tag, "_edges_to_rsp"}, n + 1, 5);
    check({tag, "_rdata"}, o_rsp_rdata, exp_rdata);
    check({tag, "_err"}, o_rsp_err, 1'b0);
    tick();
    check({tag, "_rsp_pulse"}, o_rsp_valid, 1'b0);
    check({tag, "_ready_after"}, o_req_ready, 1'b1);
    check({tag, "_rdata_hold"}, o_rsp_rdata, exp_rdata);
  endtask

  initial begin
    rst_n       = 1'b0;
    i_req_valid = 1'b1;
    i_req_write = 1'b1;
    i_req_addr  = 8'hEE;
    i_req_wdata = 8'hEE;
    i_mem_rdata = 8'hA5;
    i_mem_ack   = 1'b1;

    // Reset state, with a request presented that must be ignored.
    tick();
    tick();
    check("rst_ready", o_req_ready, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_cs", o_mem_cs, 1'b0);
    check("rst_we", o_mem_we, 1'b0);
    check("rst_valid", o_rsp_valid, 1'b0);
    check("rst_err", o_rsp_err, 1'b0);
    check("rst_rdata", o_rsp_rdata, 8'h00);
    check("rst_addr", o_mem_addr, 8'h00);
    check("rst_wdata", o_mem_wdata, 8'h00);
    i_req_valid = 1'b0;
    rst_n       = 1'b1;
    tick();
    check("post_rst_idle", o_busy, 1'b0);

    // Read 0x3C returning 0xA5, then write 0x10 <- 0x5A leaving rdata alone.
    run_txn(1'b0, 8'h3C, 8'h00, 8'hA5, "read1");
    run_txn(1'b1, 8'h10, 8'h5A, 8'hA5, "write1");

    // Ack low through the wait states (one stray pulse), then 6 cycles low.
    i_mem_ack   = 1'b0;
    i_mem_rdata = 8'hC3;
    i_req_valid = 1'b1;
    i_req_write = 1'b0;
    i_req_addr  = 8'h77;
    tick();                      // SETUP
    i_req_valid = 1'b0;
    tick();                      // ACCESS, counter 2
    i_mem_ack = 1'b1;            // sampled while counter != 0
    tick();                      // counter 1
    i_mem_ack = 1'b0;
    check("stall_no_early_rsp", o_rsp_valid, 1'b0);
    tick();                      // counter 0
    for (int i = 0; i < 6; i++) begin
      check("stall_cs", o_mem_cs, 1'b1);
      check("stall_valid", o_rsp_valid, 1'b0);
      tick();
    end
    check("stall_cs_last", o_mem_cs, 1'b1);
    i_mem_ack = 1'b1;
    tick();
    check("stall_rsp", o_rsp_valid, 1'b1);
    check("stall_rdata", o_rsp_rdata, 8'hC3);
    check("stall_cs_off", o_mem_cs, 1'b0);
    tick();
    check("stall_pulse", o_rsp_valid, 1'b0);

    // Back-to-back: request held high, alternating read/write.
    for (int k = 0; k < 4; k++) begin
      logic [7:0] exp_rd;
      i_req_valid = 1'b1;
      i_req_write = k[0];
      i_req_addr  = 8'h40 + 8'(k);
      i_req_wdata = 8'h80 + 8'(k);
      i_mem_rdata = 8'h20 + 8'(k);
      exp_rd      = (k < 2) ? 8'h20 : 8'h22;
      check("b2b_ready", o_req_ready, 1'b1);
      tick();
      check("b2b_addr", o_mem_addr, 8'h40 + 8'(k));
      check("b2b_we", o_mem_we, k[0]);
      check("b2b_not_ready", o_req_ready, 1'b0);
      tick();
      tick();
      tick();
      check("b2b_cs_held", o_mem_cs, 1'b1);
      tick();
      check("b2b_rsp", o_rsp_valid, 1'b1);
      check("b2b_rdata", o_rsp_rdata, exp_rd);
      if (k == 3) i_req_valid = 1'b0;
      tick();
      check("b2b_idle_gap", o_busy, 1'b0);
      check("b2b_pulse", o_rsp_valid, 1'b0);
    end
    tick();
    check("b2b_no_dup", o_busy, 1'b0);

    // Asynchronous reset in the middle of an ACCESS.
    i_req_valid = 1'b1;
    i_req_write = 1'b1;
    i_req_addr  = 8'h55;
    i_req_wdata = 8'h66;
    tick();
    i_req_valid = 1'b0;
    tick();
    tick();
    check("mid_cs_before", o_mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs", o_mem_cs, 1'b0);
    check("mid_rst_we", o_mem_we, 1'b0);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_ready", o_req_ready, 1'b1);
    check("mid_rst_valid", o_rsp_valid, 1'b0);
    tick();
    check("mid_rst_no_rsp", o_rsp_valid, 1'b0);
    rst_n       = 1'b1;
    i_mem_rdata = 8'h99;
    run_txn(1'b0, 8'h21, 8'h00, 8'h99, "after_rst");

    // Access that is never acknowledged.
    i_mem_ack   = 1'b0;
    i_req_valid = 1'b1;
    i_req_write = 1'b0;
    i_req_addr  = 8'h0F;
    tick();
    i_req_valid = 1'b0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 2; i <= 18; i++) begin
      tick();
      check("to_wait", o_rsp_valid, 1'b0);
    end
    tick();
    check("to_rsp", o_rsp_valid, 1'b1);
    check("to_err", o_rsp_err, 1'b1);
    check("to_rdata", o_rsp_rdata, 8'h99);
    tick();
    check("to_err_clear", o_rsp_err, 1'b0);
    check("to_idle", o_req_ready, 1'b1);
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      check("noack_busy", o_busy, 1'b1);
      check("noack_valid", o_rsp_valid, 1'b0);
    end
    check("noack_err", o_rsp_err, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_responder.md
Name: mem_access_responder

Overview:
- Memory-side responder for the core's data/program memory port.
- Accepts single read/write requests from the core, runs them on an external SRAM-style bus, and returns read data to the core data bus.
- One outstanding request at a time.
- Inserts a programmable number of wait states and requires a memory acknowledge before completing.

Parameters:
DATA_WIDTH, 8, width of data words (matches core data bus)
ADDR_WIDTH, 8, width of memory address
WAIT_CYCLES, 2, minimum ACCESS-state wait states before ack is sampled (0 allowed)
TIMEOUT_CYCLES, 15, cycles after wait expiry without ack before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_req_valid  input  1  core request strobe
i_req_write  input  1  1 = write, 0 = read
i_req_addr  input  ADDR_WIDTH  request address
i_req_wdata  input  DATA_WIDTH  write data
o_req_ready  output  1  responder can accept a request
o_rsp_valid  output  1  one-cycle completion pulse
o_rsp_rdata  output  DATA_WIDTH  last captured read data
o_rsp_err  output  1  completion was a timeout abort (qualified by o_rsp_valid)
o_busy  output  1  transaction in flight
o_mem_cs  output  1  memory chip select
o_mem_we  output  1  memory write enable
o_mem_addr  output  ADDR_WIDTH  memory address
o_mem_wdata  output  DATA_WIDTH  memory write data
i_mem_rdata  input  DATA_WIDTH  memory read data
i_mem_ack  input  1  memory acknowledge

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - Address, wdata, write, rdata and counter registers = 0.
  - o_rsp_valid = 0, o_rsp_err = 0, o_mem_cs = 0, o_mem_we = 0, o_busy = 0, o_req_ready = 1.
  - No request is captured while rst_n is low.
- o_req_ready = (state == IDLE).
- o_busy = (state == SETUP or ACCESS or RESP).
- o_mem_cs = (state == SETUP or ACCESS).
- o_mem_we = o_mem_cs & captured write flag.
- o_mem_addr and o_mem_wdata come from capture registers and are stable for the whole transaction.
- IDLE:
  - Handshake completes when i_req_valid and o_req_ready are both high at a rising edge.
  - On handshake: capture addr, wdata and write; go to SETUP.
  - i_req_valid while not ready is ignored; the core must hold it.
- SETUP (exactly 1 cycle): load wait counter with WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - If counter != 0: decrement; i_mem_ack is ignored.
  - If counter == 0 and i_mem_ack = 1: on a read, capture i_mem_rdata into o_rsp_rdata; go to RESP.
  - Writes leave o_rsp_rdata unchanged.
- RESP (exactly 1 cycle): o_rsp_valid = 1; go to IDLE. Back-to-back requests are therefore separated by at least one IDLE cycle.
- Latency: with i_mem_ack held high, o_rsp_valid is high in the cycle following the (WAIT_CYCLES+2)-th rising edge after the accepting edge.
- o_rsp_rdata holds its value until the next successful read completion.
- Counter width is clog2(WAIT_CYCLES+1), minimum 1 bit. No wrap: the counter stops at 0.
- Async reset mid-transaction aborts immediately: cs/we drop without waiting for ack, and no o_rsp_valid is generated.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A timeout counter, cleared on entering ACCESS, increments each ACCESS cycle once the wait counter is 0 and ack is low.
  - When it reaches TIMEOUT_CYCLES, go to RESP with o_rsp_err = 1 and o_rsp_valid = 1.
  - o_rsp_rdata is not updated; o_rsp_err clears in the next cycle.
  - An ack on the same edge as the timeout takes priority: normal completion, err = 0.
- Undefined: o_rsp_err is tied 0, no timeout counter exists, and ACCESS waits for ack indefinitely.

Test Plan:
- Reset, ack tied high, WAIT_CYCLES=2; read addr 0x3C with i_mem_rdata=0xA5 -> cs high for 4 cycles, we=0, o_mem_addr=0x3C, o_rsp_valid 1-cycle pulse 4 edges after accept, o_rsp_rdata=0xA5.
- Write addr 0x10 data 0x5A -> o_mem_we high with cs, o_mem_wdata=0x5A throughout, o_rsp_valid pulse, o_rsp_rdata still 0xA5.
- Ack held low for 6 cycles after wait expiry, then high -> cs held throughout, o_rsp_valid only after the ack edge; ack pulsed during counter!=0 has no effect.
- i_req_valid held high with alternating read/write -> each accepted only when o_req_ready=1, one IDLE cycle between transactions, no request lost or duplicated.
- Assert rst_n low mid-ACCESS -> cs/we/busy drop immediately, no o_rsp_valid, o_req_ready=1; the next request completes normally.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=15, ack never asserted -> o_rsp_valid and o_rsp_err=1 together after 15 post-wait cycles, o_rsp_rdata unchanged; without the macro, busy remains high indefinitely.
